// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller with 256-bit lines.
// Hits complete combinationally; misses go through optional WRITEBACK, then ALLOCATE.
module dcache_ctrl #(
   parameter int unsigned LINES = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         core_req_i,
   input  logic         core_wen_i,
   input  logic [31:0]  core_addr_i,
   input  logic [31:0]  core_wdata_i,
   output logic [31:0]  core_rdata_o,
   output logic         core_stall_o,
   output logic         DDATA_ren,
   output logic         DDATA_wen,
   output logic [26:0]  DDATA_addr,
   output logic [255:0] DDATA_wdata,
   input  logic [255:0] DDATA_rdata,
   input  logic         DDATA_ready
);

   localparam int unsigned IW = $clog2(LINES);
   localparam int unsigned TW = 27 - IW;

   typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

   state_e             state_q;
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;
   logic [TW-1:0]      tag_q  [LINES];
   logic [255:0]       data_q [LINES];

   logic [IW-1:0]      idx;
   logic [TW-1:0]      tag;
   logic [2:0]         off;
   logic               hit;
   logic               miss;
   logic [31:0]        hit_word;
   logic               unused_addr_bits;

   assign off              = core_addr_i[4:2];
   assign idx              = core_addr_i[5 +: IW];
   assign tag              = core_addr_i[31 -: TW];
   assign unused_addr_bits = ^core_addr_i[1:0];

   assign hit      = core_req_i && (state_q == StIdle) && valid_q[idx] && (tag_q[idx] == tag);
   assign miss     = core_req_i && (state_q == StIdle) && !hit;
   assign hit_word = data_q[idx][{off, 5'd0} +: 32];

   assign core_rdata_o = (hit && !core_wen_i) ? hit_word : 32'd0;
   assign core_stall_o = (core_req_i && !hit) || (state_q != StIdle);

   // Control state and memory-side request outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         valid_q     <= '0;
         dirty_q     <= '0;
         DDATA_ren   <= 1'b0;
         DDATA_wen   <= 1'b0;
         DDATA_addr  <= '0;
         DDATA_wdata <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (hit && core_wen_i) begin
                  dirty_q[idx] <= 1'b1;
               end else if (miss) begin
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_q     <= StWriteback;
                     DDATA_wen   <= 1'b1;
                     DDATA_addr  <= {tag_q[idx], idx};
                     DDATA_wdata <= data_q[idx];
                  end else begin
                     state_q    <= StAllocate;
                     DDATA_ren  <= 1'b1;
                     DDATA_addr <= {tag, idx};
                  end
               end
            end
            StWriteback: begin
               if (DDATA_ready) begin
                  state_q      <= StAllocate;
                  dirty_q[idx] <= 1'b0;
                  DDATA_wen    <= 1'b0;
                  DDATA_wdata  <= '0;
                  DDATA_ren    <= 1'b1;
                  DDATA_addr   <= {tag, idx};
               end
            end
            StAllocate: begin
               if (DDATA_ready) begin
                  state_q      <= StIdle;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  DDATA_ren    <= 1'b0;
                  DDATA_addr   <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Line payload and tags: no reset needed, validity is tracked by valid_q.
   always_ff @(posedge clk_i) begin
      if (hit && core_wen_i) begin
         data_q[idx][{off, 5'd0} +: 32] <= core_wdata_i;
      end
      if ((state_q == StAllocate) && DDATA_ready) begin
         data_q[idx] <= DDATA_rdata;
         tag_q[idx]  <= tag;
      end
   end

endmodule
